// File: rtl/fpga_cmd_rx_pkg.sv
// Shared constants for the SPI command receiver: command codes, LF major modes
// and the receive FSM state encoding.
package fpga_cmd_pkg;

  typedef enum logic [3:0] {
    CMD_NOP                       = 4'd0,
    CMD_SET_CONFREG               = 4'd1,
    CMD_SET_DIVISOR               = 4'd2,
    CMD_SET_EDGE_DETECT_THRESHOLD = 4'd3,
    CMD_READ                      = 4'd15
  } cmd_e;

  typedef enum logic [2:0] {
    MODE_READER      = 3'd0,
    MODE_EDGE_DETECT = 3'd1,
    MODE_PASSTHRU    = 3'd2,
    MODE_ADC         = 3'd3,
    MODE_OFF         = 3'd7
  } lf_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } rx_state_e;

  // The bit counter must hold FRAME_W+1 so that long frames stay distinguishable.
  function automatic int cnt_width(input int frame_w);
    return $clog2(frame_w + 2);
  endfunction

endpackage

// File: rtl/fpga_cmd_rx_if.sv
// SPI pin bundle between the ARM (master) and the FPGA command receiver (slave).
interface fpga_cmd_rx_if;
  logic spck;
  logic mosi;
  logic ncs;
  logic miso;

  modport master (output spck, output mosi, output ncs, input miso);
  modport slave  (input spck, input mosi, input ncs, output miso);
endinterface

// File: rtl/fpga_cmd_rx_spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, followed by one extra
// flop so rising and falling edges can be seen as single-cycle pulses.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_nreset,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Flops clear to 0 so that a chip select still low after reset never
  // produces a falling edge and a half-received frame is silently dropped.
  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/fpga_cmd_rx.sv
// SPI command receiver on the pck0 domain: captures fixed-length frames, writes
// strobed configuration registers, checks frame length and serves readback.
module fpga_cmd_rx
  import fpga_cmd_pkg::*;
#(
  parameter int CMD_W       = 4,
  parameter int DATA_W      = 12,
  parameter int NUM_REGS    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_SRC    = 0,
  parameter int AUTO_LSB    = 6,
  parameter int AUTO_MODE   = int'(MODE_EDGE_DETECT),
  parameter int AUTO_DST    = 2,
  parameter int AUTO_VAL    = 127
) (
  input  logic                       i_pck0,
  input  logic                       i_nreset,
  fpga_cmd_rx_if.slave               spi,
  output logic [NUM_REGS*DATA_W-1:0] o_regs,
  output logic [NUM_REGS-1:0]        o_wr_stb,
  output logic                       o_frame_err
);

  localparam int FRAME_W  = CMD_W + DATA_W;
  localparam int CNT_W    = cnt_width(FRAME_W);
  localparam int READ_CMD = (2 ** CMD_W) - 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  logic w_spck_level, w_spck_rise, w_spck_fall;
  logic w_mosi_level, w_mosi_rise, w_mosi_fall;
  logic w_ncs_level,  w_ncs_rise,  w_ncs_fall;
  logic w_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_spck_sync (
    .i_clk    (i_pck0),
    .i_nreset (i_nreset),
    .i_d      (spi.spck),
    .o_level  (w_spck_level),
    .o_rise   (w_spck_rise),
    .o_fall   (w_spck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
    .i_clk    (i_pck0),
    .i_nreset (i_nreset),
    .i_d      (spi.mosi),
    .o_level  (w_mosi_level),
    .o_rise   (w_mosi_rise),
    .o_fall   (w_mosi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ncs_sync (
    .i_clk    (i_pck0),
    .i_nreset (i_nreset),
    .i_d      (spi.ncs),
    .o_level  (w_ncs_level),
    .o_rise   (w_ncs_rise),
    .o_fall   (w_ncs_fall)
  );

  assign w_unused = w_spck_level ^ w_mosi_rise ^ w_mosi_fall ^ w_ncs_level;

  rx_state_e           r_state;
  logic [FRAME_W-1:0]  r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [FRAME_W-1:0]  r_rd_buf;
  logic [FRAME_W-1:0]  r_rd_sh;
  logic                r_miso;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_stb;
  logic                r_frame_err;

  logic [CMD_W-1:0]    w_cmd;
  logic [DATA_W-1:0]   w_data;
  logic                w_valid;
  logic                w_is_write;
  logic                w_auto_hit;

  assign w_cmd      = r_shift[FRAME_W-1 -: CMD_W];
  assign w_data     = r_shift[DATA_W-1:0];
  assign w_valid    = (r_bit_cnt == CNT_FULL);
  assign w_is_write = (int'(w_cmd) >= 1) && (int'(w_cmd) <= NUM_REGS);
  assign w_auto_hit = (int'(w_cmd) == AUTO_SRC + 1) &&
                      (w_data[AUTO_LSB +: 3] == 3'(AUTO_MODE));

  // Receive FSM. A spck rise in the same cycle as the ncs rise is shifted in
  // before the move to COMMIT, so the closing bit is never lost.
  always_ff @(posedge i_pck0) begin
    if (!i_nreset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_rd_buf    <= '0;
      r_rd_sh     <= '0;
      r_miso      <= 1'b0;
      r_wr_stb    <= '0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_wr_stb    <= '0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_miso <= 1'b0;
          if (w_ncs_fall) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_miso    <= r_rd_buf[FRAME_W-1];
            r_rd_sh   <= {r_rd_buf[FRAME_W-2:0], 1'b0};
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_spck_rise) begin
            r_shift <= {r_shift[FRAME_W-2:0], w_mosi_level};
            if (r_bit_cnt != CNT_SAT) begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
          if (w_spck_fall) begin
            r_miso  <= r_rd_sh[FRAME_W-1];
            r_rd_sh <= {r_rd_sh[FRAME_W-2:0], 1'b0};
          end
          if (w_ncs_rise) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_miso   <= 1'b0;
          r_rd_buf <= '0;
          r_state  <= ST_IDLE;
          if (!w_valid) begin
            r_frame_err <= 1'b1;
          end else if (w_cmd == '0) begin
            r_rd_buf <= '0;
          end else if (w_is_write) begin
            // Auto-default first so a frame write to the same register overrides it.
            if (w_auto_hit) begin
              r_regs[AUTO_DST]   <= DATA_W'(AUTO_VAL);
              r_wr_stb[AUTO_DST] <= 1'b1;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
              if (int'(w_cmd) == i + 1) begin
                r_regs[i]   <= w_data;
                r_wr_stb[i] <= 1'b1;
              end
            end
          end else if (int'(w_cmd) == READ_CMD) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (w_data == DATA_W'(i)) begin
                r_rd_buf <= FRAME_W'(r_regs[i]);
              end
            end
          end else begin
            r_frame_err <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign o_regs[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign o_wr_stb    = r_wr_stb;
  assign o_frame_err = r_frame_err;
  assign spi.miso    = r_miso;

endmodule
